bk_chunked_add_ctrl: RTL and testbench

- Sequences a wide modular-exponentiation add/subtract through one narrow combinational Brent-Kung adder slice.
- Processes one CHUNK_W-bit slice per clock, least-significant first, and registers the carry between slices.
- Sits between the modexp datapath (Montgomery accumulate / final-subtract) and the shared adder.
- Accepts operands on a valid/ready handshake and returns the full-width result and carry-out on a second valid/ready handshake.

---
 rtl/bk_pkg.sv | 18 +
 rtl/bk_slice_adder.sv | 58 +++++
 rtl/bk_chunked_add_ctrl.sv | 136 +++++++++++++
 tb/tb_bk_chunked_add_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// Shared types and defaults for the chunked Brent-Kung add/subtract controller.
// The slice helper keeps the chunk-to-bit-offset mapping in one place.
package bk_pkg;

    localparam int BK_CHUNK_W = 8;
    localparam int BK_NCHUNK  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bk_state_e;

    function automatic int unsigned slice_lo(input int unsigned k, input int unsigned chunk_w);
        return k * chunk_w;
    endfunction

endpackage

// File: rtl/bk_slice_adder.sv
// Combinational W-bit Brent-Kung adder with carry-in and carry-out.
// Carry-in is folded into bit 0's generate so the prefix tree yields carries directly.
module bk_slice_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    localparam int TOP_D = (W > 1) ? (2 ** ($clog2(W) - 1)) : 1;

    // {g, p} pair per bit position
    function automatic logic [1:0] pg_cell(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

    function automatic logic [1:0] black_cell(input logic [1:0] hi, input logic [1:0] lo);
        return {hi[1] | (hi[0] & lo[1]), hi[0] & lo[0]};
    endfunction

    function automatic logic gray_cell(input logic [1:0] hi, input logic [1:0] lo);
        return hi[1] | (hi[0] & lo[1]);
    endfunction

    logic [1:0]   pg [W];
    logic [W-1:0] p_bit;

    always_comb begin
        for (int i = 0; i < W; i++) begin
            pg[i]    = pg_cell(a_i[i], b_i[i]);
            p_bit[i] = pg[i][0];
        end
        pg[0][1] = gray_cell(pg[0], {cin_i, 1'b0});

        for (int d = 1; d < W; d = d * 2) begin
            for (int i = 2 * d - 1; i < W; i = i + 2 * d) begin
                pg[i] = black_cell(pg[i], pg[i - d]);
            end
        end

        // down-sweep fills in the prefixes the up-sweep skipped
        for (int d = TOP_D; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < W; i = i + 2 * d) begin
                pg[i][1] = gray_cell(pg[i], pg[i - d]);
            end
        end

        sum_o[0] = p_bit[0] ^ cin_i;
        for (int i = 1; i < W; i++) begin
            sum_o[i] = p_bit[i] ^ pg[i - 1][1];
        end
        cout_o = pg[W - 1][1];
    end

endmodule

// File: rtl/bk_chunked_add_ctrl.sv
// Sequences a wide add/subtract through one narrow Brent-Kung slice, LSB chunk first,
// with the inter-slice carry held in a single flop.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for an operand request, in_ready high
//   RUN     | one chunk per cycle through the slice adder
//   DONE    | result and cout held with out_valid until consumer takes it
module bk_chunked_add_ctrl
    import bk_pkg::*;
#(
    parameter  int CHUNK_W = BK_CHUNK_W,
    parameter  int NCHUNK  = BK_NCHUNK,
    localparam int TOTAL_W = CHUNK_W * NCHUNK,
    localparam int CNT_W   = $clog2(NCHUNK)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [TOTAL_W-1:0] op_a,
    input  logic [TOTAL_W-1:0] op_b,
    input  logic               sub,
    input  logic               cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TOTAL_W-1:0] sum,
    output logic               cout,
    output logic               busy
);

    if (NCHUNK < 2) begin : g_bad_nchunk
        $error("bk_chunked_add_ctrl: NCHUNK must be at least 2");
    end

    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

    bk_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [TOTAL_W-1:0] a_q, a_d;
    logic [TOTAL_W-1:0] b_q, b_d;
    logic [TOTAL_W-1:0] sum_q, sum_d;
    logic               cout_q, cout_d;

    logic [CHUNK_W-1:0] slice_a;
    logic [CHUNK_W-1:0] slice_b;
    logic [CHUNK_W-1:0] slice_sum;
    logic               slice_cout;
    logic               accept;

    assign slice_a = a_q[slice_lo(32'(cnt_q), CHUNK_W) +: CHUNK_W];
    assign slice_b = b_q[slice_lo(32'(cnt_q), CHUNK_W) +: CHUNK_W];

    bk_slice_adder #(
        .W (CHUNK_W)
    ) u_slice_adder (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        in_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_RUN: begin
                carry_d = slice_cout;
                sum_d[slice_lo(32'(cnt_q), CHUNK_W) +: CHUNK_W] = slice_sum;
                if (cnt_q == LAST_CHUNK) begin
                    cout_d  = slice_cout;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // same-cycle handoff: a consumer taking the result frees the slot
                in_ready = out_ready;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        accept = in_valid && in_ready;
        if (accept) begin
            a_d     = op_a;
            b_d     = sub ? ~op_b : op_b;
            carry_d = sub | cin;
            cnt_d   = '0;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_bk_chunked_add_ctrl.sv
// Directed and randomised bench for bk_chunked_add_ctrl against a cycle-level
// transaction model: each accepted op becomes visible NCHUNK edges later.
module tb_bk_chunked_add_ctrl;

    localparam int CW = 8;
    localparam int NC = 4;
    localparam int TW = CW * NC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [TW-1:0] op_a = '0;
    logic [TW-1:0] op_b = '0;
    logic          sub = 1'b0;
    logic          cin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [TW-1:0] sum;
    logic          cout;
    logic          busy;

    bk_chunked_add_ctrl #(
        .CHUNK_W (CW),
        .NCHUNK  (NC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference result: {cout, sum} = A + B' + c0
    function automatic logic [TW:0] ref_op(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                           input logic s, input logic c);
        logic [TW:0] bb;
        bb = s ? {1'b0, ~b} : {1'b0, b};
        return {1'b0, a} + bb + ((s | c) ? 33'd1 : 33'd0);
    endfunction

    // transaction model
    bit          chk_en = 1'b0;
    bit          m_valid = 1'b0;
    int          m_rem = 0;
    logic [TW:0] m_pend = '0;
    logic [TW-1:0] m_sum = '0;
    logic        m_cout = 1'b0;
    bit          m_post_rst = 1'b1;
    int          m_results = 0;

    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            m_valid    = 1'b0;
            m_rem      = 0;
            m_sum      = '0;
            m_cout     = 1'b0;
            m_post_rst = 1'b1;
        end else begin
            acc = in_valid && ((!m_valid && m_rem == 0) || (m_valid && out_ready));
            if (m_valid && out_ready) begin
                m_valid = 1'b0;
                m_results++;
            end else if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_valid          = 1'b1;
                    {m_cout, m_sum}  = m_pend;
                end
            end
            if (acc) begin
                m_rem      = NC;
                m_pend     = ref_op(op_a, op_b, sub, cin);
                m_post_rst = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("in_ready", 64'(in_ready),
                64'((!m_valid && m_rem == 0) || (m_valid && out_ready)));
            chk("busy", 64'(busy), 64'(m_valid || m_rem > 0));
            if (m_valid || m_post_rst) begin
                chk("sum", 64'(sum), 64'(m_sum));
                chk("cout", 64'(cout), 64'(m_cout));
            end
            chk("cnt_range", 64'(dut.cnt_q < NC), 64'd1);
        end
    end

    // called just after a posedge; returns just after the accepting edge
    task automatic issue(input logic [TW-1:0] a, input logic [TW-1:0] b,
                         input logic s, input logic c);
        int n;
        op_a     = a;
        op_b     = b;
        sub      = s;
        cin      = c;
        in_valid = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (n == 200) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // counts edges until out_valid is seen; returns at that negedge
    task automatic wait_valid(output int edges);
        edges = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            if (edges >= 200) begin
                chk("valid_timeout", 64'd0, 64'd1);
                break;
            end
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic take(output logic [TW-1:0] s, output logic c);
        s = sum;
        c = cout;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [TW-1:0] rs;
        logic        rc;
        int          r0;
        bit          prod_done;

        chk("ref_pin_ripple", 64'(ref_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0)), 64'h1_0000_0000);
        chk("ref_pin_borrow", 64'(ref_op(32'd5, 32'd7, 1'b1, 1'b0)), 64'h0_FFFF_FFFE);
        chk("ref_pin_sub", 64'(ref_op(32'd7, 32'd5, 1'b1, 1'b0)), 64'h1_0000_0002);
        chk("ref_pin_cin", 64'(ref_op(32'd1, 32'd1, 1'b0, 1'b1)), 64'h0_0000_0003);

        @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        @(posedge clk);
        #1;

        // full carry ripple
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        wait_valid(lat);
        chk("ripple_latency", 64'(lat), 64'd4);
        take(rs, rc);
        chk("ripple_sum", 64'(rs), 64'h0);
        chk("ripple_cout", 64'(rc), 64'd1);

        // subtract with and without borrow
        issue(32'd5, 32'd7, 1'b1, 1'b0);
        wait_valid(lat);
        take(rs, rc);
        chk("borrow_sum", 64'(rs), 64'hFFFF_FFFE);
        chk("borrow_cout", 64'(rc), 64'd0);
        issue(32'd7, 32'd5, 1'b1, 1'b1);
        wait_valid(lat);
        take(rs, rc);
        chk("sub_sum", 64'(rs), 64'h2);
        chk("sub_cout", 64'(rc), 64'd1);

        // backpressure with an ignored request
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) begin
                in_valid = 1'b1;
                op_a     = 32'hDEAD_BEEF;
                op_b     = 32'h0BAD_F00D;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_sum", 64'(sum), 64'h2345_6789);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        take(rs, rc);
        chk("hold_take_sum", 64'(rs), 64'h2345_6789);
        chk("hold_take_cout", 64'(rc), 64'd0);
        @(negedge clk);
        chk("hold_no_extra_op", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // back-to-back handoff
        issue(32'd2, 32'd3, 1'b0, 1'b0);
        wait_valid(lat);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op_a      = 32'd1;
        op_b      = 32'd1;
        sub       = 1'b0;
        cin       = 1'b1;
        @(negedge clk);
        chk("b2b_in_ready", 64'(in_ready), 64'd1);
        chk("b2b_prev_sum", 64'(sum), 64'd5);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wait_valid(lat);
        chk("b2b_latency", 64'(lat), 64'd4);
        take(rs, rc);
        chk("b2b_sum", 64'(rs), 64'd3);
        chk("b2b_cout", 64'(rc), 64'd0);

        // reset during the second RUN cycle
        issue(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_sum", 64'(sum), 64'd0);
        chk("mid_rst_cout", 64'(cout), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        issue(32'd2, 32'd3, 1'b0, 1'b0);
        wait_valid(lat);
        take(rs, rc);
        chk("post_rst_sum", 64'(rs), 64'd5);

        // randomised traffic with consumer stalls
        r0        = m_results;
        prod_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    issue($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                prod_done = 1'b1;
            end
            begin
                while (!prod_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        for (int n = 0; n < 50 && (m_valid || m_rem > 0); n++) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        chk("rand_drained", 64'(m_valid || m_rem > 0), 64'd0);
        chk("rand_results", 64'(m_results - r0), 64'd1000);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
